// File: rtl/rob_superscalar.sv
// Superscalar reorder buffer: circular N-entry queue with NUM_WB writeback ports,
// up to COMMIT_WIDTH in-order retirements per cycle, operand bypass and precise flush.
module rob_superscalar #(
  parameter int N               = 16,
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = $clog2(N),
  parameter int REG_INDEX_SIZE  = 5,
  parameter int NUM_WB          = 3,
  parameter int COMMIT_WIDTH    = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     alloc_valid_i,
  input  logic                                     alloc_is_store_i,
  input  logic [REG_INDEX_SIZE-1:0]                alloc_rd_i,
  input  logic [WORD_SIZE-1:0]                     alloc_pc_i,
  input  logic                                     alloc_exception_i,
  output logic [ROB_ENTRY_WIDTH-1:0]               assigned_rob_id_o,
  output logic                                     full_o,
  input  logic [NUM_WB-1:0]                        wb_valid_i,
  input  logic [NUM_WB*ROB_ENTRY_WIDTH-1:0]        wb_rob_id_i,
  input  logic [NUM_WB*WORD_SIZE-1:0]              wb_value_i,
  input  logic [NUM_WB-1:0]                        wb_exception_i,
  input  logic [ROB_ENTRY_WIDTH-1:0]               rs1_rob_entry_i,
  input  logic [ROB_ENTRY_WIDTH-1:0]               rs2_rob_entry_i,
  output logic [WORD_SIZE-1:0]                     bypass_s1_o,
  output logic [WORD_SIZE-1:0]                     bypass_s2_o,
  output logic                                     bypass_s1_valid_o,
  output logic                                     bypass_s2_valid_o,
  output logic [COMMIT_WIDTH-1:0]                  commit_o,
  output logic [COMMIT_WIDTH*REG_INDEX_SIZE-1:0]   commit_rd_o,
  output logic [COMMIT_WIDTH*WORD_SIZE-1:0]        commit_value_o,
  output logic [COMMIT_WIDTH*ROB_ENTRY_WIDTH-1:0]  commit_rob_entry_o,
  output logic                                     sb_store_permission_o,
  output logic [ROB_ENTRY_WIDTH-1:0]               sb_rob_id_o,
  output logic                                     exception_o,
  output logic [WORD_SIZE-1:0]                     ex_pc_o
);

  localparam int RW    = ROB_ENTRY_WIDTH;
  localparam int RI    = REG_INDEX_SIZE;
  localparam int CNT_W = RW + 1;

  typedef logic [RW-1:0] id_t;

  logic [N-1:0]         valid_q, valid_d, ready_q, ready_d, exc_q, exc_d;
  logic [N-1:0]         is_store_q;
  logic [RI-1:0]        rd_q    [N];
  logic [WORD_SIZE-1:0] pc_q    [N];
  logic [WORD_SIZE-1:0] value_q [N];

  id_t                  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d, n_retire;

  id_t                  wb_id  [NUM_WB];
  logic [WORD_SIZE-1:0] wb_val [NUM_WB];
  id_t                  slot_idx [COMMIT_WIDTH];
  logic                 scan_live;
  logic                 alloc_fire;

  logic [1:0][RW-1:0]   rs_id;
  logic [WORD_SIZE-1:0] byp_val [2];
  logic                 byp_vld [2];

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wb_id[p]  = wb_rob_id_i[p*RW +: RW];
      wb_val[p] = wb_value_i[p*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Fullness looks at the registered count only: slots freed by this cycle's commit
  // are not reusable until the next cycle.
  assign full_o            = (count_q == CNT_W'(N));
  assign assigned_rob_id_o = tail_q;
  assign exception_o       = valid_q[head_q] && ready_q[head_q] && exc_q[head_q];
  assign ex_pc_o           = exception_o ? pc_q[head_q] : '0;
  assign alloc_fire        = alloc_valid_i && !full_o && !exception_o;

  // In-order commit scan from the head; a store may only retire from slot 0, alone.
  always_comb begin
    commit_o              = '0;
    commit_rd_o           = '0;
    commit_value_o        = '0;
    commit_rob_entry_o    = '0;
    sb_store_permission_o = 1'b0;
    n_retire              = '0;
    scan_live             = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      slot_idx[k] = head_q + id_t'(k);
      if (scan_live && (CNT_W'(k) < count_q) && valid_q[slot_idx[k]] &&
          ready_q[slot_idx[k]] && !exc_q[slot_idx[k]] &&
          (!is_store_q[slot_idx[k]] || k == 0)) begin
        commit_o[k]                       = 1'b1;
        commit_rd_o[k*RI +: RI]           = rd_q[slot_idx[k]];
        commit_value_o[k*WORD_SIZE +: WORD_SIZE] = value_q[slot_idx[k]];
        commit_rob_entry_o[k*RW +: RW]    = slot_idx[k];
        n_retire                          = n_retire + CNT_W'(1);
        if (is_store_q[slot_idx[k]]) begin
          sb_store_permission_o = 1'b1;
          scan_live             = 1'b0;
        end
      end else begin
        scan_live = 1'b0;
      end
    end
    sb_rob_id_o = sb_store_permission_o ? head_q : '0;
  end

  assign rs_id = {rs2_rob_entry_i, rs1_rob_entry_i};

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      byp_val[s] = '0;
      byp_vld[s] = 1'b0;
      if (valid_q[rs_id[s]] && ready_q[rs_id[s]] && !exc_q[rs_id[s]]) begin
        byp_val[s] = value_q[rs_id[s]];
        byp_vld[s] = 1'b1;
      end
      // NOTE: later loop iterations overwrite earlier ones, so the highest port wins.
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && wb_id[p] == rs_id[s]) begin
          byp_val[s] = wb_val[p];
          byp_vld[s] = 1'b1;
        end
      end
      if (!rst_n) begin
        byp_val[s] = '0;
        byp_vld[s] = 1'b0;
      end
    end
  end

  assign bypass_s1_o       = byp_val[0];
  assign bypass_s2_o       = byp_val[1];
  assign bypass_s1_valid_o = byp_vld[0];
  assign bypass_s2_valid_o = byp_vld[1];

  always_comb begin
    valid_d = valid_q;
    ready_d = ready_q;
    exc_d   = exc_q;
    head_d  = head_q + id_t'(n_retire);
    tail_d  = tail_q + id_t'(alloc_fire);
    count_d = count_q + CNT_W'(alloc_fire) - n_retire;
    if (exception_o) begin
      valid_d = '0;
      ready_d = '0;
      exc_d   = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_valid_i[p] && valid_q[wb_id[p]]) begin
          ready_d[wb_id[p]] = 1'b1;
          exc_d[wb_id[p]]   = wb_exception_i[p];
        end
      end
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_o[k]) begin
          valid_d[slot_idx[k]] = 1'b0;
          ready_d[slot_idx[k]] = 1'b0;
          exc_d[slot_idx[k]]   = 1'b0;
        end
      end
      if (alloc_fire) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = alloc_exception_i;
        exc_d[tail_q]   = alloc_exception_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ready_q <= '0;
      exc_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      exc_q   <= exc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage has no reset; every read is qualified by valid_q/ready_q.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_WB; p++) begin
      if (!exception_o && wb_valid_i[p] && valid_q[wb_id[p]]) begin
        value_q[wb_id[p]] <= wb_val[p];
      end
    end
    if (alloc_fire) begin
      is_store_q[tail_q] <= alloc_is_store_i;
      rd_q[tail_q]       <= alloc_rd_i;
      pc_q[tail_q]       <= alloc_pc_i;
    end
  end

endmodule

// File: tb/tb_rob_superscalar.sv
// Self-checking bench for rob_superscalar: directed scenarios then random traffic,
// compared against a queue-based model of program-order entries.
module tb_rob_superscalar;

  localparam int N   = 16;
  localparam int W   = 32;
  localparam int RW  = 4;
  localparam int RI  = 5;
  localparam int NWB = 3;
  localparam int CW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 alloc_valid, alloc_is_store, alloc_exception;
  logic [RI-1:0]        alloc_rd;
  logic [W-1:0]         alloc_pc;
  logic [RW-1:0]        assigned_rob_id;
  logic                 full;
  logic [NWB-1:0]       wb_valid, wb_exception;
  logic [NWB*RW-1:0]    wb_rob_id;
  logic [NWB*W-1:0]     wb_value;
  logic [RW-1:0]        rs1_rob_entry, rs2_rob_entry;
  logic [W-1:0]         bypass_s1, bypass_s2;
  logic                 bypass_s1_valid, bypass_s2_valid;
  logic [CW-1:0]        commit;
  logic [CW*RI-1:0]     commit_rd;
  logic [CW*W-1:0]      commit_value;
  logic [CW*RW-1:0]     commit_rob_entry;
  logic                 sb_store_permission;
  logic [RW-1:0]        sb_rob_id;
  logic                 exception;
  logic [W-1:0]         ex_pc;

  rob_superscalar #(.N(N), .WORD_SIZE(W), .ROB_ENTRY_WIDTH(RW), .REG_INDEX_SIZE(RI),
                    .NUM_WB(NWB), .COMMIT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_is_store_i(alloc_is_store), .alloc_rd_i(alloc_rd),
    .alloc_pc_i(alloc_pc), .alloc_exception_i(alloc_exception),
    .assigned_rob_id_o(assigned_rob_id), .full_o(full),
    .wb_valid_i(wb_valid), .wb_rob_id_i(wb_rob_id), .wb_value_i(wb_value),
    .wb_exception_i(wb_exception),
    .rs1_rob_entry_i(rs1_rob_entry), .rs2_rob_entry_i(rs2_rob_entry),
    .bypass_s1_o(bypass_s1), .bypass_s2_o(bypass_s2),
    .bypass_s1_valid_o(bypass_s1_valid), .bypass_s2_valid_o(bypass_s2_valid),
    .commit_o(commit), .commit_rd_o(commit_rd), .commit_value_o(commit_value),
    .commit_rob_entry_o(commit_rob_entry),
    .sb_store_permission_o(sb_store_permission), .sb_rob_id_o(sb_rob_id),
    .exception_o(exception), .ex_pc_o(ex_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          ready;
    bit          exc;
    bit          st;
    bit [RI-1:0] rd;
    bit [W-1:0]  pc;
    bit [W-1:0]  value;
  } ent_t;

  ent_t mq[$];
  int   mtail;
  int   errors = 0;
  int   checks = 0;

  bit          a_v, a_st, a_exc;
  bit [RI-1:0] a_rd;
  bit [W-1:0]  a_pc;
  bit          wbv [NWB];
  int          wbid [NWB];
  bit [W-1:0]  wbval [NWB];
  bit          wbe [NWB];
  int          rs1, rs2;

  bit          e_full, e_perm, e_exc, e_b1v, e_b2v;
  int          e_aid, e_sbid, n_ret;
  bit [CW-1:0] e_commit;
  bit [CW*RI-1:0] e_crd;
  bit [CW*W-1:0]  e_cval;
  bit [CW*RW-1:0] e_cid;
  bit [W-1:0]  e_expc, e_b1, e_b2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    a_v = 0; a_st = 0; a_exc = 0; a_rd = '0; a_pc = '0;
    for (int p = 0; p < NWB; p++) begin
      wbv[p] = 0; wbid[p] = 0; wbval[p] = '0; wbe[p] = 0;
    end
    rs1 = 0; rs2 = 0;
  endtask

  task automatic drive();
    alloc_valid = a_v; alloc_is_store = a_st; alloc_exception = a_exc;
    alloc_rd = a_rd; alloc_pc = a_pc;
    for (int p = 0; p < NWB; p++) begin
      wb_valid[p]              = wbv[p];
      wb_rob_id[p*RW +: RW]    = RW'(wbid[p]);
      wb_value[p*W +: W]       = wbval[p];
      wb_exception[p]          = wbe[p];
    end
    rs1_rob_entry = RW'(rs1);
    rs2_rob_entry = RW'(rs2);
  endtask

  task automatic lookup(input int rs, output bit [W-1:0] v, output bit vld);
    v = '0; vld = 0;
    foreach (mq[i]) if (mq[i].id == rs && mq[i].ready && !mq[i].exc) begin
      v = mq[i].value; vld = 1;
    end
    for (int p = 0; p < NWB; p++) if (wbv[p] && wbid[p] == rs) begin
      v = wbval[p]; vld = 1;
    end
  endtask

  task automatic compute_expected();
    e_full = (mq.size() == N); e_aid = mtail;
    e_commit = '0; e_crd = '0; e_cval = '0; e_cid = '0;
    e_perm = 0; e_sbid = 0; e_exc = 0; e_expc = '0; n_ret = 0;
    if (mq.size() > 0) begin
      if (mq[0].ready && mq[0].exc) begin
        e_exc = 1; e_expc = mq[0].pc;
      end else if (mq[0].ready && mq[0].st) begin
        e_commit[0] = 1; e_perm = 1; e_sbid = mq[0].id; n_ret = 1;
        e_crd[RI-1:0] = mq[0].rd; e_cval[W-1:0] = mq[0].value; e_cid[RW-1:0] = RW'(mq[0].id);
      end else begin
        for (int k = 0; k < CW && k < mq.size(); k++) begin
          if (!mq[k].ready || mq[k].exc || mq[k].st) break;
          e_commit[k] = 1; n_ret++;
          e_crd[k*RI +: RI] = mq[k].rd;
          e_cval[k*W +: W]  = mq[k].value;
          e_cid[k*RW +: RW] = RW'(mq[k].id);
        end
      end
    end
    lookup(rs1, e_b1, e_b1v);
    lookup(rs2, e_b2, e_b2v);
  endtask

  task automatic model_update();
    if (e_exc) begin
      mq.delete(); mtail = 0;
    end else begin
      for (int p = 0; p < NWB; p++) if (wbv[p]) begin
        foreach (mq[i]) if (mq[i].id == wbid[p]) begin
          mq[i].ready = 1; mq[i].value = wbval[p]; mq[i].exc = wbe[p];
        end
      end
      repeat (n_ret) void'(mq.pop_front());
      if (a_v && !e_full) begin
        ent_t e;
        e.id = mtail; e.ready = a_exc; e.exc = a_exc; e.st = a_st;
        e.rd = a_rd; e.pc = a_pc; e.value = '0;
        mq.push_back(e);
        mtail = (mtail + 1) % N;
      end
    end
  endtask

  task automatic settle();
    drive();
    #1;
    compute_expected();
    check("full", full, e_full);
    check("assigned_id", assigned_rob_id, e_aid);
    check("commit", commit, e_commit);
    check("commit_rd", commit_rd, e_crd);
    check("commit_value", commit_value, e_cval);
    check("commit_id", commit_rob_entry, e_cid);
    check("sb_perm", sb_store_permission, e_perm);
    check("sb_id", sb_rob_id, e_sbid);
    check("exception", exception, e_exc);
    check("ex_pc", ex_pc, e_expc);
    check("byp1", bypass_s1, e_b1);
    check("byp1_vld", bypass_s1_valid, e_b1v);
    check("byp2", bypass_s2, e_b2);
    check("byp2_vld", bypass_s2_valid, e_b2v);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
    idle();
  endtask

  task automatic step();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive();
    #1;
    check("rst_full", full, 0);
    check("rst_aid", assigned_rob_id, 0);
    check("rst_commit", commit, 0);
    check("rst_commit_rd", commit_rd, 0);
    check("rst_commit_value", commit_value, 0);
    check("rst_commit_id", commit_rob_entry, 0);
    check("rst_sb_perm", sb_store_permission, 0);
    check("rst_sb_id", sb_rob_id, 0);
    check("rst_exc", exception, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_byp1", bypass_s1, 0);
    check("rst_byp1_vld", bypass_s1_valid, 0);
    check("rst_byp2", bypass_s2, 0);
    check("rst_byp2_vld", bypass_s2_valid, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete(); mtail = 0;
    idle();
  endtask

  initial begin
    idle();
    drive();
    @(negedge clk);
    do_reset();

    // Fill all 16 entries, then a 17th allocation must be refused.
    for (int i = 0; i < N; i++) begin
      a_v = 1; a_rd = RI'(i); a_pc = W'(i * 4);
      step();
    end
    a_v = 1; a_rd = 5'd31;
    settle();
    check("full_after_16", full, 1);
    check("aid_wrapped", assigned_rob_id, 0);
    advance();
    settle();
    check("tail_stays_0", assigned_rob_id, 0);
    advance();
    do_reset();

    // Dual commit once ids 0 and 1 are both ready.
    for (int i = 0; i < 3; i++) begin
      a_v = 1; a_rd = RI'(i + 1); a_pc = W'(32'h40 + i * 4);
      step();
    end
    wbv[1] = 1; wbid[1] = 1; wbval[1] = 32'hAA;
    step();
    wbv[0] = 1; wbid[0] = 0; wbval[0] = 32'h55;
    step();
    settle();
    check("dual_commit", commit, 2'b11);
    check("dual_values", commit_value, {32'hAA, 32'h55});
    check("dual_ids", commit_rob_entry, {4'd1, 4'd0});
    advance();
    settle();
    check("id2_waits", commit, 0);
    advance();
    wbv[0] = 1; wbid[0] = 2; wbval[0] = 32'h33;
    step();
    step();

    // Two ports hit id3 in one cycle: port 2 wins for bypass and storage.
    a_v = 1; a_rd = 5'd7; a_pc = 32'h80;
    step();
    wbv[0] = 1; wbid[0] = 3; wbval[0] = 32'h11;
    wbv[2] = 1; wbid[2] = 3; wbval[2] = 32'h22;
    rs1 = 3;
    settle();
    check("fwd_value", bypass_s1, 32'h22);
    check("fwd_valid", bypass_s1_valid, 1);
    advance();
    settle();
    check("prio_commit", commit, 2'b01);
    check("prio_value", commit_value[W-1:0], 32'h22);
    advance();
    do_reset();

    // Store at head retires alone, ALU behind it retires next cycle.
    a_v = 1; a_st = 1; a_rd = 5'd9; a_pc = 32'h200;
    step();
    a_v = 1; a_rd = 5'd10; a_pc = 32'h204;
    step();
    wbv[0] = 1; wbid[0] = 0; wbval[0] = 32'h5;
    wbv[1] = 1; wbid[1] = 1; wbval[1] = 32'h77;
    step();
    settle();
    check("store_perm", sb_store_permission, 1);
    check("store_sb_id", sb_rob_id, 0);
    check("store_alone", commit, 2'b01);
    check("store_rd", commit_rd[RI-1:0], 5'd9);
    advance();
    settle();
    check("alu_after_store", commit, 2'b01);
    check("alu_after_store_id", commit_rob_entry[RW-1:0], 1);
    advance();
    do_reset();

    // Faulting id2 behind two good entries, with an allocation in the flush cycle.
    for (int i = 0; i < 3; i++) begin
      a_v = 1; a_rd = RI'(i + 3); a_pc = W'(32'hF0 + i * 8);
      step();
    end
    wbv[0] = 1; wbid[0] = 0; wbval[0] = 32'h1;
    wbv[1] = 1; wbid[1] = 1; wbval[1] = 32'h2;
    wbv[2] = 1; wbid[2] = 2; wbval[2] = 32'h3; wbe[2] = 1;
    step();
    settle();
    check("pre_exc_commit", commit, 2'b11);
    advance();
    a_v = 1; a_rd = 5'd12; a_pc = 32'h300;
    settle();
    check("exc_flag", exception, 1);
    check("exc_pc", ex_pc, 32'h100);
    check("exc_no_commit", commit, 0);
    advance();
    settle();
    check("flush_aid", assigned_rob_id, 0);
    check("flush_full", full, 0);
    check("flush_commit", commit, 0);
    advance();
    do_reset();

    // Move head/tail to 14, then retire across the wrap point.
    for (int i = 0; i < 14; i++) begin
      a_v = 1; a_rd = RI'(i); a_pc = W'(i * 4);
      if (i > 0) begin
        wbv[0] = 1; wbid[0] = i - 1; wbval[0] = W'(i * 3);
      end
      step();
    end
    wbv[0] = 1; wbid[0] = 13; wbval[0] = 32'h99;
    step();
    repeat (8) step();
    for (int i = 0; i < 4; i++) begin
      a_v = 1; a_rd = RI'(20 + i); a_pc = W'(32'h400 + i * 4);
      step();
    end
    wbv[0] = 1; wbid[0] = 14; wbval[0] = 32'hE14;
    wbv[1] = 1; wbid[1] = 15; wbval[1] = 32'hE15;
    step();
    settle();
    check("wrap_ids_hi", commit_rob_entry, {4'd15, 4'd14});
    advance();
    wbv[0] = 1; wbid[0] = 0; wbval[0] = 32'hE00;
    wbv[1] = 1; wbid[1] = 1; wbval[1] = 32'hE01;
    step();
    settle();
    check("wrap_ids_lo", commit_rob_entry, {4'd1, 4'd0});
    advance();

    // Random traffic with one reset asserted mid-stream.
    for (int cyc = 0; cyc < 400; cyc++) begin
      a_v   = ($urandom % 10) < 6;
      a_st  = ($urandom % 4) == 0;
      a_exc = ($urandom % 20) == 0;
      a_rd  = RI'($urandom);
      a_pc  = $urandom;
      for (int p = 0; p < NWB; p++) begin
        wbv[p]   = $urandom % 2;
        wbid[p]  = (mq.size() > 0 && ($urandom % 4) != 0) ?
                   mq[$urandom_range(0, mq.size() - 1)].id : int'($urandom % N);
        wbval[p] = $urandom;
        wbe[p]   = ($urandom % 25) == 0;
      end
      rs1 = int'($urandom % N);
      rs2 = int'($urandom % N);
      if (cyc == 200) do_reset();
      else step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
